// File: rtl/run_pkg.sv
// Shared types and default sizing for the run launcher and its counters.
package run_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } run_state_e;

    localparam int CNT_W_DEF       = 32;
    localparam int REP_W_DEF       = 8;
    localparam int ACK_TIMEOUT_DEF = 16;

    // The ack counter must hold ACK_TIMEOUT itself, hence the extra bit.
    function automatic int ack_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/run_launcher_if.sv
// Host/callee signal bundle of the run launcher; master is the launcher's view.
interface run_launcher_if #(
    parameter int CNT_W = 32,
    parameter int REP_W = 8
) ();
    logic             ce;
    logic             i_start;
    logic [REP_W-1:0] i_count;
    logic             o_ready;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_cycles;
    logic             o_timeout;
    logic             o_run_req;
    logic             i_run_busy;

    modport master (
        input  ce, i_start, i_count, i_run_busy,
        output o_ready, o_busy, o_done, o_cycles, o_timeout, o_run_req
    );

    modport slave (
        output ce, i_start, i_count, i_run_busy,
        input  o_ready, o_busy, o_done, o_cycles, o_timeout, o_run_req
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q_o,
    output logic [W-1:0] inc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // inc_o is the value the counter takes if enabled this edge.
    assign inc_o = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign q_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = inc_o;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/run_launcher.sv
// Issues a programmable number of back-to-back run_req/run_busy calls to a callee,
// timing the whole sequence and flagging callees that never acknowledge.
module run_launcher
    import run_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int REP_W       = REP_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input logic           clock,
    input logic           reset,
    run_launcher_if.master bus
);
    localparam int              ACK_W    = ack_width(ACK_TIMEOUT);
    localparam bit              ACK_EN   = (ACK_TIMEOUT != 0);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    run_state_e       state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic [ACK_W-1:0] ack_q, ack_inc_unused;
    logic             ready, accept;
    logic             cnt_clr, cnt_en, ack_clr, ack_en;

    assign ready  = (state_q == S_IDLE) && !bus.i_run_busy;
    assign accept = bus.ce && bus.i_start && ready;

    assign cnt_clr = accept;
    assign cnt_en  = bus.ce && (state_q == S_REQ || state_q == S_WAIT || state_q == S_RUN);
    assign ack_clr = bus.ce && (state_q == S_REQ);
    assign ack_en  = bus.ce && (state_q == S_WAIT) && !bus.i_run_busy;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q_o   (cnt_q),
        .inc_o (cnt_inc)
    );

    sat_counter #(.W(ACK_W)) u_ack (
        .clock (clock),
        .reset (reset),
        .clr   (ack_clr),
        .en    (ack_en),
        .q_o   (ack_q),
        .inc_o (ack_inc_unused)
    );

    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;
        if (bus.ce) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rep_d     = (bus.i_count == '0) ? REP_W'(1) : bus.i_count;
                        timeout_d = 1'b0;
                        state_d   = S_REQ;
                    end
                end
                S_REQ:  state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.i_run_busy) begin
                        state_d = S_RUN;
                    end else if (ACK_EN && ack_q == ACK_LAST) begin
                        // Callee never answered: abandon any remaining runs.
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
                S_RUN: begin
                    if (!bus.i_run_busy) begin
                        rep_d   = rep_q - 1'b1;
                        state_d = (rep_q == REP_W'(1)) ? S_DONE : S_REQ;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            // Loaded with the post-edge count so o_cycles is valid alongside o_done.
            if (state_d == S_DONE && state_q != S_DONE)
                cycles_d = cnt_inc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rep_q     <= '0;
            timeout_q <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            rep_q     <= rep_d;
            timeout_q <= timeout_d;
            cycles_q  <= cycles_d;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_done    = (state_q == S_DONE);
    assign bus.o_run_req = (state_q == S_REQ);
    assign bus.o_cycles  = cycles_q;
    assign bus.o_timeout = timeout_q;
endmodule

// File: tb/tb_run_launcher.sv
// Bench for run_launcher: table vectors, hand-written corner sequences, random runs.
module tb_run_launcher;
    localparam int CNT_W = 32;
    localparam int REP_W = 8;
    localparam int ACK_T = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Callee model: busy for k_cur ce-edges, starting the cycle after a sampled request.
    int   k_cur      = 5;
    int   rem        = 0;
    bit   callee_off = 1'b0;
    bit   hold_busy  = 1'b0;

    run_launcher_if #(.CNT_W(CNT_W), .REP_W(REP_W)) bus ();

    run_launcher #(.CNT_W(CNT_W), .REP_W(REP_W), .ACK_TIMEOUT(ACK_T)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.ce) begin
            if (rem != 0)
                rem <= rem - 1;
            else if (bus.o_run_req && !callee_off)
                rem <= k_cur;
        end
    end
    assign bus.i_run_busy = hold_busy | (rem != 0);

    typedef struct {
        int count;
        int k;
        bit noresp;
        int exp_cycles;
        bit exp_tmo;
        int exp_reqs;
        int exp_lat;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Whole-run reference: each completed run costs REQ+WAIT+K cycles, a silent callee
    // costs REQ plus ACK_T waiting cycles and ends the sequence.
    function automatic void model(input int count, input int k, input bit noresp,
                                  output int cyc, output bit tmo, output int reqs);
        int n;
        n = (count == 0) ? 1 : count;
        if (noresp) begin
            cyc = 1 + ACK_T; tmo = 1'b1; reqs = 1;
        end else begin
            cyc = n * (k + 2); tmo = 1'b0; reqs = n;
        end
    endfunction

    // ce_mode: 0 = always on, 1 = alternating, 2 = random. exp_lat < 0 skips latency.
    task automatic run_one(input string tag, input int count, input int k, input bit noresp,
                           input int ce_mode, input int exp_cyc, input bit exp_tmo,
                           input int exp_reqs, input int exp_lat);
        logic [CNT_W+4:0] snap, prev;
        bit  prev_ce, got_done, frozen_ok;
        int  lat, reqs, cyc;
        bit  tmo;
        k_cur = k; callee_off = noresp;
        reqs = 0; lat = 0; got_done = 1'b0; frozen_ok = 1'b1; prev_ce = 1'b1;
        cyc = 0; tmo = 1'b0; prev = '0;
        @(negedge clock);
        chk({tag, " ready_at_start"}, bus.o_ready, 1);
        bus.i_count = REP_W'(count); bus.i_start = 1'b1; bus.ce = 1'b1;
        @(negedge clock);
        bus.i_start = 1'b0;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            lat++;
            snap = {bus.o_ready, bus.o_busy, bus.o_done, bus.o_timeout, bus.o_run_req, bus.o_cycles};
            if (!prev_ce && snap != prev) frozen_ok = 1'b0;
            if (lat == 1) begin
                chk({tag, " busy_after_accept"}, bus.o_busy, 1);
                chk({tag, " timeout_cleared"}, bus.o_timeout, 0);
            end
            if (bus.o_done) begin
                got_done = 1'b1;
                cyc = bus.o_cycles; tmo = bus.o_timeout;
                bus.ce = 1'b1;
            end else begin
                case (ce_mode)
                    1:       bus.ce = (lat % 2 == 0);
                    2:       bus.ce = ($urandom_range(0, 3) != 0);
                    default: bus.ce = 1'b1;
                endcase
                if (bus.o_run_req && bus.ce) reqs++;
                prev = snap; prev_ce = bus.ce;
                @(negedge clock);
            end
        end
        chk({tag, " done_seen"}, got_done, 1);
        chk({tag, " cycles"}, cyc, exp_cyc);
        chk({tag, " timeout"}, tmo, exp_tmo);
        chk({tag, " req_pulses"}, reqs, exp_reqs);
        if (exp_lat >= 0) chk({tag, " done_latency"}, lat, exp_lat);
        if (ce_mode != 0) chk({tag, " frozen_when_ce_low"}, frozen_ok, 1);
        @(negedge clock);
        chk({tag, " done_one_pulse"}, bus.o_done, 0);
        chk({tag, " cycles_held"}, bus.o_cycles, exp_cyc);
        chk({tag, " timeout_held"}, bus.o_timeout, exp_tmo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   cyc, reqs, dones, cnt, k, cm;
        bit   tmo, nr;
        logic [CNT_W+3:0] outs;

        vecs[0] = '{count: 1,   k: 5, noresp: 0, exp_cycles: 7,   exp_tmo: 0, exp_reqs: 1,   exp_lat: 8};
        vecs[1] = '{count: 3,   k: 4, noresp: 0, exp_cycles: 18,  exp_tmo: 0, exp_reqs: 3,   exp_lat: 19};
        vecs[2] = '{count: 0,   k: 3, noresp: 0, exp_cycles: 5,   exp_tmo: 0, exp_reqs: 1,   exp_lat: 6};
        vecs[3] = '{count: 1,   k: 0, noresp: 1, exp_cycles: 17,  exp_tmo: 1, exp_reqs: 1,   exp_lat: 18};
        vecs[4] = '{count: 2,   k: 6, noresp: 0, exp_cycles: 16,  exp_tmo: 0, exp_reqs: 2,   exp_lat: 17};
        vecs[5] = '{count: 2,   k: 1, noresp: 0, exp_cycles: 6,   exp_tmo: 0, exp_reqs: 2,   exp_lat: 7};
        vecs[6] = '{count: 255, k: 1, noresp: 0, exp_cycles: 765, exp_tmo: 0, exp_reqs: 255, exp_lat: 766};

        bus.ce = 1'b0; bus.i_start = 1'b0; bus.i_count = '0;
        repeat (3) @(negedge clock);
        outs = {bus.o_busy, bus.o_done, bus.o_timeout, bus.o_run_req, bus.o_cycles};
        chk("reset_outputs_zero", outs, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", bus.o_ready, 1);

        // Start while the callee is still busy must be ignored.
        hold_busy = 1'b1;
        @(negedge clock);
        chk("ready_low_while_callee_busy", bus.o_ready, 0);
        bus.i_start = 1'b1; bus.ce = 1'b1;
        @(negedge clock);
        bus.i_start = 1'b0;
        dones = 0;
        repeat (4) begin
            if (bus.o_run_req || bus.o_busy) dones++;
            @(negedge clock);
        end
        chk("start_ignored_when_not_ready", dones, 0);
        hold_busy = 1'b0;

        for (int i = 0; i < 7; i++)
            run_one($sformatf("vec%0d", i), vecs[i].count, vecs[i].k, vecs[i].noresp, 0,
                    vecs[i].exp_cycles, vecs[i].exp_tmo, vecs[i].exp_reqs, vecs[i].exp_lat);

        run_one("ce_toggle", 1, 5, 1'b0, 1, 7, 1'b0, 1, -1);

        // Reset while the callee is mid-run.
        k_cur = 10; callee_off = 1'b0;
        @(negedge clock);
        bus.i_count = 8'd1; bus.i_start = 1'b1; bus.ce = 1'b1;
        @(negedge clock);
        bus.i_start = 1'b0;
        repeat (4) @(negedge clock);
        chk("busy_before_mid_reset", bus.o_busy, 1);
        #2 reset = 1'b1;
        #1;
        outs = {bus.o_busy, bus.o_done, bus.o_timeout, bus.o_run_req, bus.o_cycles};
        chk("mid_reset_outputs_zero", outs, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (bus.o_done) dones++;
            if (bus.o_ready) break;
        end
        chk("no_done_after_reset", dones, 0);
        chk("ready_once_callee_idle", bus.o_ready, 1);
        run_one("post_reset", 1, 5, 1'b0, 0, 7, 1'b0, 1, 8);

        for (int i = 0; i < 20; i++) begin
            cnt = $urandom_range(0, 4);
            k   = $urandom_range(1, 6);
            nr  = ($urandom_range(0, 5) == 0);
            cm  = $urandom_range(0, 2);
            model(cnt, k, nr, cyc, tmo, reqs);
            run_one($sformatf("rand%0d", i), cnt, k, nr, cm, cyc, tmo, reqs,
                    (cm == 0) ? cyc + 1 : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
